seq_unsigned_divider: RTL
=========================

SEQ_UNSIGNED_DIVIDER -- requirements
Module: seq_unsigned_divider

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the operand width in bits (N >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 The block SHALL have port A, input, N bits: unsigned dividend; captured on the accepted start.
REQ-006 The block SHALL have port B, input, N bits: unsigned divisor; captured on the accepted start.
REQ-007 The block SHALL have port busy, output, 1 bit: high in CALC and DONE.
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle result-valid pulse.
REQ-009 The block SHALL have port quotient, output, N bits: unsigned A/B.
REQ-010 The block SHALL have port remainder, output, N bits: unsigned A mod B.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: B was 0 for the current result.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-013 In IDLE with start=1 and B!=0, the next edge SHALL capture A and B, clear the partial remainder and bit counter, clear div_by_zero, and enter CALC.
REQ-014 Each CALC cycle SHALL perform one restoring step, MSB first: shift {rem, dividend-msb} left; if the (N+1)-bit trial value >= B, subtract B and set the quotient bit to 1, else restore and set it to 0.
REQ-015 CALC SHALL last exactly N cycles, then enter DONE.
REQ-016 In DONE, quotient and remainder SHALL be final and done=1 for exactly one cycle, followed by an unconditional return to IDLE.
REQ-017 Latency from the start edge to done high SHALL be N+1 cycles (5 for N=4).
REQ-018 In IDLE with start=1 and B=0, the block SHALL go directly to DONE: quotient all ones, remainder=A, div_by_zero=1, done on the next cycle.
REQ-019 start while busy=1 SHALL be ignored and SHALL NOT alter the captured operands.
REQ-020 Changes on A or B after the accepted start SHALL NOT affect the result.
REQ-021 quotient, remainder and div_by_zero SHALL hold their values after done until the next accepted start.
REQ-022 start asserted in the IDLE cycle immediately after DONE SHALL be accepted (back-to-back throughput of N+2 cycles).
REQ-023 The internal trial subtraction SHALL be N+1 bits wide so no carry is lost for B >= 2^(N-1).

Reset
REQ-024 On clk edge with rst=1, state SHALL become IDLE and busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
REQ-025 rst SHALL take priority over start and over any in-progress CALC/DONE; an aborted division SHALL produce no done pulse.

Structure
REQ-026 A shared package SHALL hold the state enum (IDLE, CALC, DONE) and the default width constant (4).
REQ-027 One combinational sub-module div_restore_step (inputs: partial remainder, next dividend bit, divisor; outputs: new remainder, quotient bit) SHALL implement REQ-014.
REQ-028 The datapath SHALL use one div_restore_step instance, reused each CALC cycle, not an unrolled array.

Verification
REQ-029 The bench SHALL drive A=13, B=10, start for one cycle, and SHALL check done high exactly 5 cycles later with quotient=1, remainder=3, and div_by_zero=0.
REQ-030 The bench SHALL drive A=10, B=3, and SHALL check quotient=3 and remainder=1; it SHALL then drive A=15, B=1 and check quotient=15 and remainder=0; it SHALL then drive A=2, B=15 and check quotient=0 and remainder=2.
REQ-031 The bench SHALL drive A=6, B=0, and SHALL check done after 1 cycle with quotient=15, remainder=6, and div_by_zero=1.
REQ-032 The bench SHALL start A=13, B=10; in CALC cycle 2 it SHALL pulse start with A=1, B=1 and change A/B; it SHALL check the result is still 1 r 3 with a single done pulse.
REQ-033 The bench SHALL start A=13, B=10 and assert rst in CALC cycle 3; it SHALL check all outputs are 0, no done pulse occurs, and a subsequent start with A=9, B=2 gives 4 r 1.
REQ-034 The bench SHALL run an exhaustive N=4 sweep over all A in 0..15 and B in 1..15 with back-to-back starts, and SHALL check quotient*B+remainder=A and remainder<B for every pair.

Source files
------------

// File: rtl/seq_unsigned_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states and default width.
package seq_unsigned_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_N = 4;

endpackage

// File: rtl/seq_unsigned_divider_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_restore_step #(
    parameter int N = 4
) (
    input  logic [N-1:0] rem,
    input  logic         bit_in,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] rem_next,
    output logic         q_bit
);

    logic [N:0] trial;
    logic [N:0] diff;

    always_comb begin
        trial = {rem, bit_in};
        diff  = trial - {1'b0, divisor};
        // rem < divisor keeps trial < 2*divisor, so diff[N] is set only on a borrow.
        q_bit    = ~diff[N];
        rem_next = q_bit ? diff[N-1:0] : trial[N-1:0];
    end

endmodule

// File: rtl/seq_unsigned_divider.sv
// Sequential unsigned restoring divider: one quotient bit per CALC cycle, MSB first.
module seq_unsigned_divider
    import seq_unsigned_divider_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N + 1);

    state_t        state_reg;
    state_t        state_next;
    logic [N-1:0]  q_reg;
    logic [N-1:0]  rem_reg;
    logic [N-1:0]  divisor_reg;
    logic [CW-1:0] count_reg;
    logic          div_by_zero_reg;
    logic [N-1:0]  step_rem;
    logic          step_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (B == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (count_reg == CW'(N - 1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    div_restore_step #(.N(N)) u_step (
        .rem      (rem_reg),
        .bit_in   (q_reg[N-1]),
        .divisor  (divisor_reg),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    // q_reg starts as the dividend and fills with quotient bits as the dividend shifts out.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg           <= '0;
            rem_reg         <= '0;
            divisor_reg     <= '0;
            count_reg       <= '0;
            div_by_zero_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (B == '0) begin
                            q_reg           <= '1;
                            rem_reg         <= A;
                            div_by_zero_reg <= 1'b1;
                        end else begin
                            q_reg           <= A;
                            rem_reg         <= '0;
                            divisor_reg     <= B;
                            count_reg       <= '0;
                            div_by_zero_reg <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem_reg   <= step_rem;
                    q_reg     <= {q_reg[N-2:0], step_q};
                    count_reg <= count_reg + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == DONE);
    assign quotient    = q_reg;
    assign remainder   = rem_reg;
    assign div_by_zero = div_by_zero_reg;

endmodule
